// File: rtl/onehot_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : onehot_req_scheduler
// Purpose  : Upstream stage for the 8-to-3 encoder.
//            - Synchronizes 8 asynchronous event lines.
//            - Detects rising edges and holds them as pending events.
//            - Presents exactly one event at a time as a legal one-hot byte.
//            The downstream encoder therefore never sees a zero-hot or
//            multi-hot code on a valid beat.
//
// Ports    : clk         single clock, rising edge
//            rst         asynchronous active-high reset
//            req_in      raw asynchronous event lines, bit i = source i
//            onehot_out  selected request; one-hot when out_valid, else 0
//            out_valid   onehot_out holds a request
//            out_ready   downstream accepts (transfer = out_valid & out_ready)
//            pending     registered pending-event vector (status)
//            overflow    1-cycle pulse when a new edge hits an already
//                        pending bit (the event is merged, i.e. lost)
//
// Options  : ONEHOT_SCHED_FIXED_PRIO_EN defined
//              -> fixed priority, highest index wins; no RR pointer.
//            ONEHOT_SCHED_FIXED_PRIO_EN undefined (default)
//              -> round-robin starting at the pointer, wrapping 7 -> 0.
//
// Revision : 1.0  initial release
// ============================================================================
module onehot_req_scheduler #(
  parameter int SYNC_STAGES = 2,  // legal 2..4
  parameter int N_REQ       = 8   // fixed at 8 to match the encoder width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] onehot_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] hist;
  logic [N_REQ-1:0] synced;
  logic [N_REQ-1:0] rise;
  logic             transfer;
  logic [N_REQ-1:0] clear;
  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] next_sel;

  // --------------------------------------------------------------------------
  // Input synchronizer chain
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~hist;
  assign transfer = out_valid & out_ready;
  assign clear    = transfer ? onehot_out : '0;
  // The bit handed off this cycle is never a candidate for the next beat,
  // even if a fresh edge re-pends it in the same cycle.
  assign avail    = pending & ~clear;

`ifdef ONEHOT_SCHED_FIXED_PRIO_EN
  // --------------------------------------------------------------------------
  // Fixed priority: highest index wins
  // --------------------------------------------------------------------------
  function automatic logic [N_REQ-1:0] pick_fixed(input logic [N_REQ-1:0] cand);
    logic [N_REQ-1:0] g;
    logic             found;
    g     = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (!found && cand[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign next_sel = pick_fixed(avail);

`else
  // --------------------------------------------------------------------------
  // Round-robin: scan upward from the start index, wrapping 7 -> 0
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] search_start;

  function automatic logic [N_REQ-1:0] pick_rr(input logic [N_REQ-1:0] cand,
                                               input logic [PTR_W-1:0] start);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [PTR_W-1:0] k;
    g     = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      // PTR_W-bit addition wraps naturally because N_REQ is a power of two
      k = start + PTR_W'(off);
      if (!found && cand[k]) begin
        g[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  assign grant_idx    = oh_to_idx(onehot_out);
  // On a transfer the pointer is about to move past the granted index; the
  // back-to-back selection already searches from that new position.
  assign search_start = transfer ? PTR_W'(grant_idx + 1'b1) : rr_ptr;
  assign next_sel     = pick_rr(avail, search_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= PTR_W'(grant_idx + 1'b1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Edge history, pending bookkeeping and presentation FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist       <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      onehot_out <= '0;
      out_valid  <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      hist     <= synced;
      // A rise on the bit being cleared wins: it stays pending as a new event.
      pending  <= (pending & ~clear) | rise;
      overflow <= |(rise & pending & ~clear);

      case (state)
        ST_IDLE: begin
          if (|pending) begin
            onehot_out <= next_sel;
            out_valid  <= 1'b1;
            state      <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (transfer) begin
            if (|avail) begin
              onehot_out <= next_sel;
            end else begin
              onehot_out <= '0;
              out_valid  <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          onehot_out <= '0;
          out_valid  <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_req_scheduler
// Purpose  : Directed, scoreboard-based bench for onehot_req_scheduler.
//            Stimulus pushes the expected grant sequence into a queue; a
//            monitor pops and compares on every accepted beat.
// Revision : 1.0  initial release
// ============================================================================
module tb_onehot_req_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] onehot_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  onehot_req_scheduler #(
    .SYNC_STAGES(2),
    .N_REQ      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .onehot_out(onehot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected grant orders for the two arbitration flavours
`ifdef ONEHOT_SCHED_FIXED_PRIO_EN
  localparam logic [7:0] T2_FIRST  = 8'h80;
  localparam logic [7:0] T2_SECOND = 8'h01;
  localparam logic [7:0] T3_A      = 8'h80;
  localparam logic [7:0] T3_C      = 8'h01;
`else
  localparam logic [7:0] T2_FIRST  = 8'h01;
  localparam logic [7:0] T2_SECOND = 8'h80;
  localparam logic [7:0] T3_A      = 8'h01;
  localparam logic [7:0] T3_C      = 8'h80;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat is accepted at the next rising edge when valid & ready
  // are high at the falling edge (inputs only change just after rising edges).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [7:0] e;
      checks++;
      if ($countones(onehot_out) != 1) begin
        errors++;
        $display("FAIL beat_legal: got %0h expected a one-hot code", onehot_out);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %0h expected no beat", onehot_out);
      end else begin
        e = exp_q.pop_front();
        if (onehot_out !== e) begin
          errors++;
          $display("FAIL beat_value: got %0h expected %0h", onehot_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s: got out_valid=0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d beats outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();  // let the final accepted beat complete
  endtask

  task automatic do_reset();
    chk("sb_empty_before_reset", 32'(exp_q.size()), 32'd0);
    rst       = 1'b1;
    req_in    = 8'h00;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ovf_cnt;
    int vld_cnt;

    rst       = 1'b1;
    req_in    = 8'h00;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_onehot",   32'(onehot_out), 32'h00);
    chk("rst_valid",    32'(out_valid),  32'h0);
    chk("rst_pending",  32'(pending),    32'h00);
    chk("rst_overflow", 32'(overflow),   32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // ---- 1: single pulse, latency and single-cycle beat -------------------
    out_ready = 1'b1;
    req_in    = 8'h04;
    exp_q.push_back(8'h04);
    repeat (3) tick();
    chk("t1_not_yet_valid", 32'(out_valid), 32'h0);
    req_in = 8'h00;
    tick();
    chk("t1_valid_k3",  32'(out_valid),  32'h1);
    chk("t1_onehot_k3", 32'(onehot_out), 32'h04);
    chk("t1_pending_k3", 32'(pending),   32'h04);
    tick();
    chk("t1_valid_drop",  32'(out_valid), 32'h0);
    chk("t1_pending_clr", 32'(pending),   32'h00);

    // ---- 1b: pointer now 3, events on bits 0 and 3 -> 08 then 01 ----------
    req_in = 8'h09;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h01);
    repeat (2) tick();
    req_in = 8'h00;
    wait_drain("t1b_drain");
    chk("t1b_pending_clr", 32'(pending), 32'h00);

    // ---- 2: simultaneous events with backpressure -------------------------
    do_reset();
    req_in = 8'h81;
    tick();
    req_in = 8'h00;
    exp_q.push_back(T2_FIRST);
    exp_q.push_back(T2_SECOND);
    wait_valid("t2_wait");
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_onehot", 32'(onehot_out), 32'(T2_FIRST));
      chk("t2_stall_valid",  32'(out_valid),  32'h1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_b2b_valid",  32'(out_valid),  32'h1);
    chk("t2_b2b_onehot", 32'(onehot_out), 32'(T2_SECOND));
    tick();
    chk("t2_valid_drop", 32'(out_valid), 32'h0);

    // ---- 3: round-robin order with wrap -----------------------------------
    do_reset();
    out_ready = 1'b1;
    req_in    = 8'h83;
    exp_q.push_back(T3_A);
    exp_q.push_back(8'h02);
    exp_q.push_back(T3_C);
    repeat (2) tick();
    req_in = 8'h00;
    wait_drain("t3_drain");
    req_in = 8'h01;
    exp_q.push_back(8'h01);
    repeat (2) tick();
    req_in = 8'h00;
    wait_drain("t3_wrap_drain");
    chk("t3_pending_clr", 32'(pending), 32'h00);

    // ---- 4: overflow on a stalled pending bit -----------------------------
    do_reset();
    ovf_cnt = 0;
    for (int ph = 0; ph < 4; ph++) begin
      req_in = (ph % 2 == 0) ? 8'h08 : 8'h00;
      repeat (4) begin
        tick();
        if (overflow) ovf_cnt++;
      end
    end
    chk("t4_overflow_count", 32'(ovf_cnt),    32'd1);
    chk("t4_pending",        32'(pending),    32'h08);
    chk("t4_onehot",         32'(onehot_out), 32'h08);
    exp_q.push_back(8'h08);
    out_ready = 1'b1;
    wait_drain("t4_drain");
    repeat (4) tick();
    chk("t4_pending_clr", 32'(pending),   32'h00);
    chk("t4_valid_drop",  32'(out_valid), 32'h0);

    // ---- 5: clear/set collision on bit 5 ----------------------------------
    do_reset();
    req_in = 8'h20;
    repeat (3) tick();
    req_in = 8'h00;
    wait_valid("t5_wait");
    repeat (4) tick();
    chk("t5_presented", 32'(onehot_out), 32'h20);
    req_in = 8'h20;               // second rise becomes visible two edges later
    repeat (2) tick();
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h20);
    out_ready = 1'b1;             // accept in the very cycle the rise is seen
    tick();
    chk("t5_no_overflow",   32'(overflow), 32'h0);
    chk("t5_pending_kept",  32'(pending),  32'h20);
    req_in = 8'h00;
    tick();
    chk("t5_no_overflow_2", 32'(overflow), 32'h0);
    wait_drain("t5_drain");
    chk("t5_pending_clr", 32'(pending), 32'h00);

    // ---- 6: asynchronous reset mid-stall ----------------------------------
    do_reset();
    req_in = 8'hF0;
    begin
      int n = 0;
      while (!(out_valid && pending == 8'hF0) && n < 50) begin
        tick();
        n++;
      end
      chk("t6_setup_pending", 32'(pending), 32'hF0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;                   // no clock edge before the following checks
    #1;
    chk("t6_async_valid",    32'(out_valid),  32'h0);
    chk("t6_async_onehot",   32'(onehot_out), 32'h00);
    chk("t6_async_pending",  32'(pending),    32'h00);
    chk("t6_async_overflow", 32'(overflow),   32'h0);
    req_in = 8'h00;
    repeat (2) tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    vld_cnt   = 0;
    repeat (10) begin
      tick();
      if (out_valid) vld_cnt++;
    end
    chk("t6_no_grant_after",   32'(vld_cnt), 32'd0);
    chk("t6_pending_after",    32'(pending), 32'h00);

    chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_req_scheduler.md
Name: onehot_req_scheduler

Overview:
- Upstream stage for the 8-to-3 encoder: collects 8 asynchronous event lines and presents exactly one request at a time as a legal one-hot byte.
- The downstream encoder therefore never sees zero-hot or multi-hot codes on a valid beat.
- Synchronizes inputs, detects rising edges, holds pending events, arbitrates round-robin and hands off via valid/ready.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input bit (legal 2..4)
N_REQ, 8, number of request lines (fixed at 8 to match encoder width; other values unsupported)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_in  input  8  raw asynchronous event lines, bit i = source i
onehot_out  output  8  selected request, exactly one bit set when out_valid=1, 8'h00 otherwise
out_valid  output  1  onehot_out holds a request
out_ready  input  1  downstream accepts; transfer when out_valid & out_ready at rising clk
pending  output  8  registered pending-event vector (status)
overflow  output  1  one-cycle pulse: new edge on a bit already pending (event merged/lost)

Behaviour:
- Reset (async assert, sync use after deassert): sync chains, edge history, pending, onehot_out = 8'h00; out_valid=0; overflow=0; RR pointer=0; FSM=IDLE.
- Sync: each req_in bit passes SYNC_STAGES flops. Edge history flop holds the previous synced value; rise[i] = synced & ~history.
- Pending update each cycle: pending_next = (pending & ~clear) | rise.
  - clear = onehot_out when a transfer occurs, else 0.
  - A rise on the bit being cleared in the same cycle wins; the bit stays pending as a new event.
- overflow = |(rise & pending & ~clear), registered, 1-cycle pulse.
- Latency (SYNC_STAGES=2, FSM IDLE): req_in rising before edge k → rise seen after edge k+1 → pending set at edge k+2 → out_valid=1 after edge k+3.
- FSM:
  - IDLE: out_valid=0, onehot_out=0. If pending≠0, register the selected one-hot, go to PRESENT.
  - PRESENT: out_valid=1. onehot_out is stable until transfer. On transfer:
    - If (pending & ~onehot_out)≠0, load the next selection and stay in PRESENT. This gives back-to-back beats with no bubble.
    - Otherwise go to IDLE.
  - out_ready low: hold state, hold onehot_out.
- Round-robin selection:
  - Search starts at the pointer index and scans upward with wrap 7→0. First pending bit wins.
  - Selection uses pending excluding the bit being cleared this cycle.
  - On transfer of index g, pointer = (g+1) mod 8. Wrap: g=7 → pointer=0.
- out_ready while out_valid=0 is ignored.
- Reset mid-transfer: everything clears immediately; in-flight and pending events are discarded.
- Edges already in the sync chain at reset release are lost, since the history flop resets to 0. A line held high through reset produces one rise after release; this is intended.

Optional Feature:
- Macro: ONEHOT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, highest index wins (bit 7 first). The RR pointer is removed.
- Undefined: round-robin as above.
- All other behaviour (handshake, overflow, latency) is identical either way.

Test Plan:
1. Reset then single pulse: req_in=8'h04 for 3 cycles, out_ready=1 → out_valid=1 with onehot_out=8'h04 at edge k+3, held exactly 1 cycle; pending returns to 8'h00.
2. Simultaneous events with backpressure: req_in 8'h00→8'h81 in one cycle, out_ready=0 for 5 cycles then 1 → onehot_out=8'h01 stable while stalled, then 8'h80 on the next cycle with no bubble; out_valid then drops.
3. Round-robin wrap: pending 8'h83, pointer=0 → grants in order 8'h01, 8'h02, 8'h80. Then a new 8'h01 event is granted next (pointer wraps to 0 after index 7).
4. Overflow: bit 3 pending and stalled (out_ready=0); toggle req_in[3] 0→1→0→1 → overflow pulses once for the second rise; bit 3 granted only once.
5. Clear/set collision: bit 5 presented and accepted in the same cycle its second rise is detected → no overflow; bit 5 re-presented later.
6. Async reset mid-stall: assert rst while out_valid=1 and pending=8'hF0 → all outputs 0 immediately, without waiting for a clock edge. After release, no grant appears unless a new rising edge occurs. With ONEHOT_SCHED_FIXED_PRIO_EN defined, rerun case 3 → grant order 8'h80, 8'h02, 8'h01.
